mem_init_engine: RTL and testbench

MEM_INIT_ENGINE -- requirements
Module: mem_init_engine

---
 rtl/mem_init_pkg.sv | 21 ++
 rtl/mem_init_addr_gen.sv | 47 ++++
 rtl/mem_init_engine.sv | 174 +++++++++++++++++
 tb/tb_mem_init_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_init_pkg.sv
// rtl/mem_init_pkg.sv - shared states, mode codes and error-count saturation for the RAM init engine
package mem_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  localparam logic [15:0] ERR_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == ERR_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_init_addr_gen.sv
// rtl/mem_init_addr_gen.sv - address/count sequencer with last flag and range check for the init engine
module mem_init_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 33000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              range_bad,
  output logic              len_zero
);

  localparam int SUM_W = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   remaining;
  logic [SUM_W-1:0]  end_addr;

  // One spare bit over base+length so the largest legal length cannot wrap past DEPTH.
  assign end_addr  = SUM_W'(base) + SUM_W'(length);
  assign range_bad = end_addr > SUM_W'(DEPTH);
  assign len_zero  = (length == '0);

  assign addr = cur;
  assign last = (remaining == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= '0;
      remaining <= '0;
    end else if (load) begin
      cur       <= base;
      remaining <= length;
    end else if (advance && (remaining != '0)) begin
      cur       <= cur + ADDR_ONE;
      remaining <= remaining - CNT_ONE;
    end
  end

endmodule

// File: rtl/mem_init_engine.sv
// rtl/mem_init_engine.sv - RAM fill/check engine; check mode compares read data one cycle after each address issue
module mem_init_engine
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 33000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   pattern,
  input  logic                addr_xor,
  output logic                busy,
  output logic                done,
  output logic                range_err,
  output logic                mismatch,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  state_t state, state_n;

  logic              mode_q;
  logic              xor_q;
  logic [DATA_W-1:0] pattern_q;

  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  logic              gen_range_bad;
  logic              gen_len_zero;
  logic              gen_load;
  logic              gen_adv;

  logic              accept;
  logic              issue_cs;
  logic              issue_wr;

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_expected;
  logic              cmp_miss;

  mem_init_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (gen_load),
    .advance   (gen_adv),
    .base      (base),
    .length    (length),
    .addr      (gen_addr),
    .last      (gen_last),
    .range_bad (gen_range_bad),
    .len_zero  (gen_len_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    gen_load = 1'b0;
    gen_adv  = 1'b0;
    issue_cs = 1'b0;
    issue_wr = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          gen_load = 1'b1;
          if (gen_range_bad || gen_len_zero) begin
            state_n = DONE;
          end else if (mode == MODE_CHECK) begin
            state_n = CHECK;
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (abort) begin
          state_n = DONE;
        end else begin
          issue_cs = 1'b1;
          issue_wr = (mode_q == MODE_FILL);
          gen_adv  = 1'b1;
          if (gen_last) begin
            state_n = DONE;
          end
        end
      end
      CHECK: begin
        if (abort) begin
          state_n = DONE;
        end else begin
          issue_cs = 1'b1;
          gen_adv  = 1'b1;
          if (gen_last) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Abort is folded into issue_cs combinationally so the RAM sees no access in the abort cycle.
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign mem_clken      = busy;
  assign mem_chipselect = issue_cs;
  assign mem_write      = issue_wr;
  assign mem_address    = gen_addr;
  assign mem_byteenable = '1;
  assign mem_writedata  = pattern_q ^ (xor_q ? DATA_W'(gen_addr) : '0);

  assign cmp_expected = pattern_q ^ (xor_q ? DATA_W'(cmp_addr) : '0);
  assign cmp_miss     = cmp_valid && !abort && (mem_readdata != cmp_expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q         <= MODE_FILL;
      xor_q          <= 1'b0;
      pattern_q      <= '0;
      range_err      <= 1'b0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
    end else begin
      cmp_valid <= (state == CHECK) && !abort;
      cmp_addr  <= gen_addr;
      if (accept) begin
        mode_q         <= mode;
        xor_q          <= addr_xor;
        pattern_q      <= pattern;
        range_err      <= gen_range_bad;
        mismatch       <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (cmp_miss) begin
        err_count <= sat_inc(err_count);
        mismatch  <= 1'b1;
        if (!mismatch) begin
          first_err_addr <= cmp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_init_engine.sv
// tb/tb_mem_init_engine.sv - directed self-checking bench for mem_init_engine
module tb_mem_init_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] base = '0;
  logic [16:0] length = '0;
  logic [31:0] pattern = '0;
  logic        addr_xor = 1'b0;
  logic        busy, done, range_err, mismatch;
  logic [15:0] err_count, first_err_addr;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_range_err, s_mismatch;
  logic [15:0] s_err_count, s_first_err_addr, s_mem_address;
  logic [3:0]  s_mem_byteenable;
  logic        s_mem_chipselect, s_mem_write, s_mem_clken;
  logic [31:0] s_mem_writedata;
  logic [31:0] s_mem_readdata = 32'hFFFF_FFFF;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:32999];
  logic        mon_clr = 1'b0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  int          cyc = 0;
  int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int          first_wr_cyc = 0, last_wr_cyc = 0;
  int          order_err = 0;
  logic [15:0] last_wr_addr = '0;

  always #5 clk = ~clk;

  mem_init_engine dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .base(base), .length(length), .pattern(pattern), .addr_xor(addr_xor),
    .busy(busy), .done(done), .range_err(range_err), .mismatch(mismatch),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  mem_init_engine #(.ADDR_W(16), .DATA_W(32), .DEPTH(65536)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .abort(1'b0), .mode(1'b1),
    .base(16'd0), .length(17'h10000), .pattern(32'h0), .addr_xor(1'b0),
    .busy(s_busy), .done(s_done), .range_err(s_range_err), .mismatch(s_mismatch),
    .err_count(s_err_count), .first_err_addr(s_first_err_addr),
    .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
    .mem_chipselect(s_mem_chipselect), .mem_write(s_mem_write),
    .mem_writedata(s_mem_writedata), .mem_clken(s_mem_clken), .mem_readdata(s_mem_readdata)
  );

  // RAM model with 1-cycle read latency plus access monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mon_clr) begin
      cs_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; order_err <= 0;
    end else if (mem_chipselect) begin
      cs_cnt <= cs_cnt + 1;
      if (mem_write) begin
        mem[mem_address] <= mem_writedata;
        if (wr_cnt == 0) first_wr_cyc <= cyc;
        else if (mem_address != last_wr_addr + 16'd1) order_err <= order_err + 1;
        last_wr_cyc  <= cyc;
        last_wr_addr <= mem_address;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_readdata <= mem[mem_address];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic do_start(input logic m, input logic [15:0] b, input logic [16:0] l,
                          input logic [31:0] p, input logic x);
    @(negedge clk);
    mode = m; base = b; length = l; pattern = p; addr_xor = x;
    start = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
    total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
      bad++; $display("FAIL reset_mem got=%0h%0h%0h want=000", mem_chipselect, mem_write, mem_clken); end
    total++; if (err_count !== 16'd0 || first_err_addr !== 16'd0 || mismatch !== 1'b0 || range_err !== 1'b0) begin
      bad++; $display("FAIL reset_status got=%0h/%0h/%0h/%0h want=0/0/0/0", err_count, first_err_addr, mismatch, range_err); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%0h want=0", busy); end
  endtask

  task automatic test_fill_check;
    logic seen;
    do_start(1'b0, 16'd0, 17'd16, 32'hA5A5_A5A5, 1'b0);
    total++; if (busy !== 1'b1 || mem_write !== 1'b1 || mem_address !== 16'd0 || mem_writedata !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL fill_first got=%0h/%0h/%0h/%0h want=1/1/0/a5a5a5a5", busy, mem_write, mem_address, mem_writedata); end
    total++; if (mem_byteenable !== 4'hF) begin bad++; $display("FAIL fill_be got=%0h want=f", mem_byteenable); end
    wait_done(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL fill_done got=0 want=1"); end
    total++; if (wr_cnt !== 16 || (last_wr_cyc - first_wr_cyc) !== 15 || order_err !== 0) begin
      bad++; $display("FAIL fill_writes got=%0d/%0d/%0d want=16/15/0", wr_cnt, last_wr_cyc - first_wr_cyc, order_err); end
    total++; if (mem[15] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL fill_word15 got=%0h want=a5a5a5a5", mem[15]); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fill_pulse got=%0h/%0h want=0/0", done, busy); end
    do_start(1'b1, 16'd0, 17'd16, 32'hA5A5_A5A5, 1'b0);
    wait_done(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL check_done got=0 want=1"); end
    total++; if (mismatch !== 1'b0 || err_count !== 16'd0 || rd_cnt !== 16 || wr_cnt !== 0) begin
      bad++; $display("FAIL check_clean got=%0h/%0h/%0d/%0d want=0/0/16/0", mismatch, err_count, rd_cnt, wr_cnt); end
    @(negedge clk);
  endtask

  task automatic test_single_fault;
    logic seen;
    do_start(1'b0, 16'd100, 17'd8, 32'h1234_5678, 1'b1);
    wait_done(30, seen);
    total++; if (!seen) begin bad++; $display("FAIL fault_fill_done got=0 want=1"); end
    total++; if (mem[103] !== 32'h1234_561F) begin bad++; $display("FAIL fault_xor_word got=%0h want=1234561f", mem[103]); end
    @(negedge clk);
    poke_addr = 16'd103; poke_data = 32'hDEAD_BEEF; poke_en = 1'b1;
    @(negedge clk); poke_en = 1'b0;
    do_start(1'b1, 16'd100, 17'd8, 32'h1234_5678, 1'b1);
    wait_done(30, seen);
    total++; if (!seen) begin bad++; $display("FAIL fault_check_done got=0 want=1"); end
    total++; if (err_count !== 16'd1 || first_err_addr !== 16'd103 || mismatch !== 1'b1) begin
      bad++; $display("FAIL fault_result got=%0d/%0d/%0h want=1/103/1", err_count, first_err_addr, mismatch); end
    @(negedge clk);
  endtask

  task automatic test_range_null;
    logic seen;
    do_start(1'b0, 16'd32990, 17'd20, 32'h0, 1'b0);
    wait_done(5, seen);
    total++; if (!seen || range_err !== 1'b1 || cs_cnt !== 0) begin
      bad++; $display("FAIL range_err got=%0h/%0h/%0d want=1/1/0", seen, range_err, cs_cnt); end
    @(negedge clk);
    do_start(1'b1, 16'd5, 17'd0, 32'h0, 1'b0);
    wait_done(5, seen);
    total++; if (!seen || range_err !== 1'b0 || cs_cnt !== 0) begin
      bad++; $display("FAIL null_run got=%0h/%0h/%0d want=1/0/0", seen, range_err, cs_cnt); end
    @(negedge clk);
    do_start(1'b0, 16'd32980, 17'd20, 32'h0000_0077, 1'b0);
    wait_done(40, seen);
    total++; if (!seen || range_err !== 1'b0 || wr_cnt !== 20 || mem[32999] !== 32'h77) begin
      bad++; $display("FAIL range_edge got=%0h/%0h/%0d/%0h want=1/0/20/77", seen, range_err, wr_cnt, mem[32999]); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic seen;
    int cs_before;
    do_start(1'b0, 16'd0, 17'd64, 32'h0F0F_0F0F, 1'b1);
    wait_done(80, seen);
    @(negedge clk);
    do_start(1'b1, 16'd0, 17'd64, 32'h0F0F_0F0F, 1'b1);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    #1;
    total++; if (mem_chipselect !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_cs got=%0h/%0h want=0/1", mem_chipselect, busy); end
    @(negedge clk);
    abort = 1'b0;
    total++; if (done !== 1'b1 || cs_cnt !== 4 || err_count !== 16'd0) begin
      bad++; $display("FAIL abort_done got=%0h/%0d/%0d want=1/4/0", done, cs_cnt, err_count); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0h want=0", busy); end
  endtask

  task automatic test_ignored_start;
    logic seen;
    do_start(1'b0, 16'd200, 17'd16, 32'h55AA_55AA, 1'b0);
    @(negedge clk);
    mode = 1'b1; base = 16'd300; length = 17'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, seen);
    total++; if (!seen || wr_cnt !== 16 || rd_cnt !== 0 || order_err !== 0 || last_wr_addr !== 16'd215) begin
      bad++; $display("FAIL ignore_start got=%0h/%0d/%0d/%0d/%0d want=1/16/0/0/215", seen, wr_cnt, rd_cnt, order_err, last_wr_addr); end
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_rerun got=%0h want=0", busy); end
    mode = 1'b0; base = 16'd0; length = 17'd4; start = 1'b1; abort = 1'b1; mon_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || cs_cnt !== 0) begin
      bad++; $display("FAIL abort_priority got=%0h/%0d want=0/0", busy, cs_cnt); end
  endtask

  task automatic test_async_reset;
    logic seen;
    int cs_snap;
    do_start(1'b0, 16'd1000, 17'd50, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
      bad++; $display("FAIL areset_fill got=%0h%0h%0h%0h%0h want=00000", busy, done, mem_chipselect, mem_write, mem_clken); end
    cs_snap = cs_cnt;
    repeat (2) @(negedge clk);
    total++; if (cs_cnt !== cs_snap || wr_cnt !== 3) begin
      bad++; $display("FAIL areset_no_access got=%0d/%0d want=%0d/3", cs_cnt, wr_cnt, cs_snap); end
    reset = 1'b0;
    do_start(1'b1, 16'd1000, 17'd50, 32'h1, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL areset_pre_miss got=%0h want=1", mismatch); end
    #2 reset = 1'b1;
    #1;
    total++; if (mismatch !== 1'b0 || err_count !== 16'd0 || first_err_addr !== 16'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL areset_check got=%0h/%0h/%0h/%0h want=0/0/0/0", mismatch, err_count, first_err_addr, busy); end
    @(negedge clk);
    reset = 1'b0;
    do_start(1'b0, 16'd400, 17'd4, 32'hCAFE_F00D, 1'b1);
    wait_done(20, seen);
    total++; if (!seen || wr_cnt !== 4 || mem[402] !== 32'hCAFE_F19F) begin
      bad++; $display("FAIL restart_fill got=%0h/%0d/%0h want=1/4/cafef19f", seen, wr_cnt, mem[402]); end
    @(negedge clk);
    do_start(1'b1, 16'd400, 17'd4, 32'hCAFE_F00D, 1'b1);
    wait_done(20, seen);
    total++; if (!seen || mismatch !== 1'b0 || err_count !== 16'd0) begin
      bad++; $display("FAIL restart_check got=%0h/%0h/%0d want=1/0/0", seen, mismatch, err_count); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    logic seen;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 66000; i++) begin
      if (s_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL sat_done got=0 want=1"); end
    total++; if (s_err_count !== 16'hFFFF || s_mismatch !== 1'b1 || s_first_err_addr !== 16'd0 || s_range_err !== 1'b0) begin
      bad++; $display("FAIL sat_count got=%0h/%0h/%0h/%0h want=ffff/1/0/0", s_err_count, s_mismatch, s_first_err_addr, s_range_err); end
  endtask

  initial begin
    #2;
    test_reset;
    test_fill_check;
    test_single_fault;
    test_range_null;
    test_abort;
    test_ignored_start;
    test_async_reset;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
